fc_psum_ctrl: RTL and testbench

//  Sequencer and partial-sum holder directly downstream of (and feeding back into) the 16-lane MAC ALU.
//  - For each output neuron, steps through cfg_chunks 16-input chunks.
//  - Drives biase_ena and pre_data to the ALU and captures its 16-bit truncated result as the running sum.
//  - After the last chunk, optionally applies ReLU.
//  - Emits one result per neuron on a valid/ready output.

---
 rtl/fc_pkg.sv | 14 +
 rtl/fc_psum_ctrl_if.sv | 29 ++
 rtl/fc_relu16.sv | 10 +
 rtl/fc_psum_ctrl.sv | 131 +++++++++++++
 tb/tb_fc_psum_ctrl.sv | 216 +++++++++++++++++++++
 5 files changed

// File: rtl/fc_pkg.sv
// rtl/fc_pkg.sv - shared widths and sequencer state encoding for the FC layer blocks
package fc_pkg;
  localparam int DATA_W  = 16;
  localparam int CHUNK_W = 8;
  localparam int NEUR_W  = 10;
  localparam int ALU_LAT = 2;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ISSUE  = 2'd1,
    WAIT   = 2'd2,
    OUTPUT = 2'd3
  } fc_state_e;
endpackage

// File: rtl/fc_psum_ctrl_if.sv
// rtl/fc_psum_ctrl_if.sv - ALU request/feedback and result stream between psum controller and neighbours
interface fc_psum_ctrl_if #(
  parameter int DATA_W  = 16,
  parameter int CHUNK_W = 8,
  parameter int NEUR_W  = 10
);
  logic              req_valid;
  logic [NEUR_W-1:0] req_neuron;
  logic [CHUNK_W-1:0] req_chunk;
  logic              biase_ena;
  logic [DATA_W-1:0] pre_data;
  logic [DATA_W-1:0] alu_data;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_data;
  logic [NEUR_W-1:0] out_neuron;

  modport master (
    output req_valid, req_neuron, req_chunk, biase_ena, pre_data,
    output out_valid, out_data, out_neuron,
    input  alu_data, out_ready
  );

  modport slave (
    input  req_valid, req_neuron, req_chunk, biase_ena, pre_data,
    input  out_valid, out_data, out_neuron,
    output alu_data, out_ready
  );
endinterface

// File: rtl/fc_relu16.sv
// rtl/fc_relu16.sv - combinational ReLU on the sign bit, bypassed when en is low
module fc_relu16 #(
  parameter int W = 16
) (
  input  logic         en,
  input  logic [W-1:0] din,
  output logic [W-1:0] dout
);
  assign dout = (en && din[W-1]) ? '0 : din;
endmodule

// File: rtl/fc_psum_ctrl.sv
// rtl/fc_psum_ctrl.sv - per-neuron chunk sequencer holding the ALU partial sum and emitting results
module fc_psum_ctrl #(
  parameter int DATA_W  = fc_pkg::DATA_W,
  parameter int CHUNK_W = fc_pkg::CHUNK_W,
  parameter int NEUR_W  = fc_pkg::NEUR_W,
  parameter int ALU_LAT = fc_pkg::ALU_LAT
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [CHUNK_W-1:0] cfg_chunks,
  input  logic [NEUR_W-1:0]  cfg_neurons,
  input  logic               relu_en,
  fc_psum_ctrl_if.master     bus,
  output logic               busy,
  output logic               done
);
  import fc_pkg::*;

  localparam int CNT_W = (ALU_LAT < 2) ? 1 : $clog2(ALU_LAT + 1);

  fc_state_e          state_q, state_d;
  logic [CHUNK_W-1:0] chunk_q, chunk_d;
  logic [CHUNK_W-1:0] last_chunk_q, last_chunk_d;
  logic [NEUR_W-1:0]  neuron_q, neuron_d;
  logic [NEUR_W-1:0]  last_neuron_q, last_neuron_d;
  logic [DATA_W-1:0]  psum_q, psum_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               relu_q, relu_d;
  logic               done_q, done_d;
  logic               in_req;
  logic [DATA_W-1:0]  relu_out;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= IDLE;
      chunk_q       <= '0;
      last_chunk_q  <= '0;
      neuron_q      <= '0;
      last_neuron_q <= '0;
      psum_q        <= '0;
      cnt_q         <= '0;
      relu_q        <= 1'b0;
      done_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      chunk_q       <= chunk_d;
      last_chunk_q  <= last_chunk_d;
      neuron_q      <= neuron_d;
      last_neuron_q <= last_neuron_d;
      psum_q        <= psum_d;
      cnt_q         <= cnt_d;
      relu_q        <= relu_d;
      done_q        <= done_d;
    end
  end

  always_comb begin
    state_d       = state_q;
    chunk_d       = chunk_q;
    last_chunk_d  = last_chunk_q;
    neuron_d      = neuron_q;
    last_neuron_d = last_neuron_q;
    psum_d        = psum_q;
    cnt_d         = cnt_q;
    relu_d        = relu_q;
    done_d        = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          // A zero count means one chunk / one neuron, so last index saturates at 0.
          last_chunk_d  = (cfg_chunks == '0) ? '0 : cfg_chunks - CHUNK_W'(1);
          last_neuron_d = (cfg_neurons == '0) ? '0 : cfg_neurons - NEUR_W'(1);
          relu_d        = relu_en;
          chunk_d       = '0;
          neuron_d      = '0;
          psum_d        = '0;
          state_d       = ISSUE;
        end
      end
      ISSUE: begin
        cnt_d   = CNT_W'(1);
        state_d = WAIT;
      end
      WAIT: begin
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_W'(ALU_LAT)) begin
          psum_d = bus.alu_data;
          if (chunk_q == last_chunk_q) begin
            state_d = OUTPUT;
          end else begin
            chunk_d = chunk_q + CHUNK_W'(1);
            state_d = ISSUE;
          end
        end
      end
      OUTPUT: begin
        if (bus.out_ready) begin
          if (neuron_q == last_neuron_q) begin
            done_d  = 1'b1;
            state_d = IDLE;
          end else begin
            neuron_d = neuron_q + NEUR_W'(1);
            chunk_d  = '0;
            state_d  = ISSUE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  fc_relu16 #(.W(DATA_W)) u_relu (
    .en   (relu_q),
    .din  (psum_q),
    .dout (relu_out)
  );

  // Bias/pre_data are only meaningful while a chunk is in flight; elsewhere they idle at 0.
  assign in_req         = (state_q == ISSUE) || (state_q == WAIT);
  assign bus.req_valid  = (state_q == ISSUE);
  assign bus.req_neuron = neuron_q;
  assign bus.req_chunk  = chunk_q;
  assign bus.biase_ena  = in_req && (chunk_q == '0);
  assign bus.pre_data   = (in_req && (chunk_q != '0)) ? psum_q : '0;
  assign bus.out_valid  = (state_q == OUTPUT);
  assign bus.out_data   = (state_q == OUTPUT) ? relu_out : '0;
  assign bus.out_neuron = neuron_q;
  assign busy           = (state_q != IDLE);
  assign done           = done_q;
endmodule

// File: tb/tb_fc_psum_ctrl.sv
// tb/tb_fc_psum_ctrl.sv - directed and randomized layers against a neuron/chunk reference model
module tb_fc_psum_ctrl;
  localparam int ALU_LAT = 2;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic [7:0] cfg_chunks;
  logic [9:0] cfg_neurons;
  logic       relu_en;
  logic       busy;
  logic       done;

  int checks = 0;
  int errors = 0;
  int vals[$];

  fc_psum_ctrl_if #(.DATA_W(16), .CHUNK_W(8), .NEUR_W(10)) bus ();

  fc_psum_ctrl #(.DATA_W(16), .CHUNK_W(8), .NEUR_W(10), .ALU_LAT(ALU_LAT)) dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .cfg_chunks  (cfg_chunks),
    .cfg_neurons (cfg_neurons),
    .relu_en     (relu_en),
    .bus         (bus),
    .busy        (busy),
    .done        (done)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0d expected %0d", tag, $signed(obs), $signed(exp));
    end
  endtask

  function automatic logic [31:0] sx(input logic [15:0] v);
    return {{16{v[15]}}, v};
  endfunction

  task automatic fill(input int n);
    vals.delete();
    for (int i = 0; i < n; i++) vals.push_back(int'($signed(16'($urandom))));
  endtask

  task automatic chk_idle();
    chk("idle_req_valid", 32'(bus.req_valid), 32'(0));
    chk("idle_req_neuron", 32'(bus.req_neuron), 32'(0));
    chk("idle_req_chunk", 32'(bus.req_chunk), 32'(0));
    chk("idle_biase_ena", 32'(bus.biase_ena), 32'(0));
    chk("idle_pre_data", 32'(bus.pre_data), 32'(0));
    chk("idle_out_valid", 32'(bus.out_valid), 32'(0));
    chk("idle_out_data", 32'(bus.out_data), 32'(0));
    chk("idle_out_neuron", 32'(bus.out_neuron), 32'(0));
    chk("idle_busy", 32'(busy), 32'(0));
    chk("idle_done", 32'(done), 32'(0));
  endtask

  // Model: request r covers neuron r/C, chunk r%C; the ALU answers vals[r]; each neuron's result is its last answer.
  task automatic run_layer(input int cc, input int nn, input bit relu, input int stall_n,
                           input int stall_len, input bit rand_ready, input bit dup_start);
    int ce, ne, r, o, since, stall_cnt, pend, exp_pre, expo;
    bit waiting, exp_b, acc_prev, acc_last, finished;
    ce = (cc == 0) ? 1 : cc;
    ne = (nn == 0) ? 1 : nn;
    r = 0; o = 0; since = 0; stall_cnt = 0; pend = 0; exp_pre = 0;
    waiting = 0; exp_b = 0; acc_prev = 0; acc_last = 0; finished = 0;
    cfg_chunks  = 8'(cc);
    cfg_neurons = 10'(nn);
    relu_en     = relu;
    start       = 1'b1;
    tick();
    start       = 1'b0;
    cfg_chunks  = 8'($urandom);
    cfg_neurons = 10'($urandom);
    relu_en     = 1'($urandom);
    chk("busy_after_start", 32'(busy), 32'(1));
    for (int cyc = 0; cyc < 3000 && !finished; cyc++) begin
      start = dup_start && (cyc == 3);
      if (acc_prev) begin
        if (acc_last) begin
          chk("done_pulse", 32'(done), 32'(1));
          chk("busy_after_done", 32'(busy), 32'(0));
          finished = 1;
        end else begin
          chk("no_bubble_req", 32'(bus.req_valid), 32'(1));
        end
      end else begin
        chk("no_early_done", 32'(done), 32'(0));
      end
      acc_prev = 0;
      if (!finished) begin
        if (bus.req_valid) begin
          chk("req_in_range", 32'(r < ce * ne), 32'(1));
          exp_b   = (r % ce) == 0;
          exp_pre = (exp_b || r >= ce * ne) ? 0 : vals[r-1];
          chk("req_neuron", 32'(bus.req_neuron), r / ce);
          chk("req_chunk", 32'(bus.req_chunk), r % ce);
          chk("biase_ena", 32'(bus.biase_ena), 32'(exp_b));
          chk("pre_data", sx(bus.pre_data), exp_pre);
          pend    = (r < ce * ne) ? vals[r] : 0;
          r++;
          since   = 0;
          waiting = 1;
        end else if (waiting) begin
          since++;
          chk("biase_hold", 32'(bus.biase_ena), 32'(exp_b));
          chk("pre_hold", sx(bus.pre_data), exp_pre);
        end
        bus.alu_data = (waiting && since == ALU_LAT) ? 16'(pend) : 16'($urandom);
        if (waiting && since == ALU_LAT) waiting = 0;
        if (bus.out_valid) begin
          chk("out_no_req", 32'(bus.req_valid), 32'(0));
          chk("out_neuron", 32'(bus.out_neuron), o);
          expo = (o < ne) ? vals[o*ce+ce-1] : 0;
          if (relu && expo < 0) expo = 0;
          chk("out_data", sx(bus.out_data), expo);
          if (o == stall_n && stall_cnt < stall_len) begin
            bus.out_ready = 1'b0;
            stall_cnt++;
          end else begin
            bus.out_ready = rand_ready ? 1'($urandom) : 1'b1;
          end
          if (bus.out_ready) begin
            o++;
            acc_prev = 1;
            acc_last = (o == ne);
          end
        end else begin
          bus.out_ready = 1'($urandom);
        end
        tick();
      end
    end
    start = 1'b0;
    chk("layer_finished", 32'(finished), 32'(1));
    chk("all_requests", r, ce * ne);
    chk("all_outputs", o, ne);
    bus.out_ready = 1'b0;
    tick();
    chk("done_one_cycle", 32'(done), 32'(0));
  endtask

  initial begin
    int cnt;
    rst = 1'b1; start = 1'b0; cfg_chunks = '0; cfg_neurons = '0; relu_en = 1'b0;
    bus.alu_data = '0; bus.out_ready = 1'b0;
    repeat (3) tick();
    chk_idle();
    rst = 1'b0;
    tick();

    // Abort mid-WAIT with a 3-cycle reset.
    cfg_chunks = 8'd2; cfg_neurons = 10'd2; start = 1'b1;
    tick();
    start = 1'b0;
    cnt = 0;
    while (!bus.req_valid && cnt < 20) begin
      tick();
      cnt++;
    end
    chk("abort_req_seen", 32'(bus.req_valid), 32'(1));
    tick();
    rst = 1'b1;
    repeat (3) begin
      tick();
      chk_idle();
    end
    rst = 1'b0;
    repeat (4) begin
      tick();
      chk("abort_no_done", 32'(done), 32'(0));
      chk("abort_idle", 32'(busy), 32'(0));
    end

    fill(1);
    vals[0] = -5;
    run_layer(1, 1, 1'b0, -1, 0, 1'b0, 1'b0);

    vals.delete();
    vals.push_back(100); vals.push_back(250); vals.push_back(400);
    run_layer(3, 1, 1'b0, -1, 0, 1'b0, 1'b0);

    fill(4);
    vals[1] = -32768;
    vals[3] = 32767;
    run_layer(2, 2, 1'b1, -1, 0, 1'b0, 1'b0);

    fill(8);
    run_layer(2, 4, 1'b0, 1, 5, 1'b0, 1'b0);

    fill(3);
    run_layer(0, 3, 1'b0, -1, 0, 1'b0, 1'b1);

    for (int k = 0; k < 5; k++) begin
      int cc, nn;
      cc = $urandom_range(0, 4);
      nn = $urandom_range(0, 4);
      fill(((cc == 0) ? 1 : cc) * ((nn == 0) ? 1 : nn));
      run_layer(cc, nn, 1'($urandom), -1, 0, 1'b1, 1'($urandom));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
